// File: rtl/add_serial_arb.sv
// Round-robin arbiter and sequencer sharing one bit-serial adder between N requesters.
// Issues the adder start/return enable pulses and returns each sum to its owner.
module add_serial_arb #(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int ADD_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           busy,
    output logic           add_en,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    input  logic [W-1:0]   add_out
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ADD_CYCLES - 1);
    localparam logic [PW-1:0] IDX_LAST = PW'(N - 1);

    typedef enum logic [2:0] {
        ST_ARB, ST_START, ST_WAIT, ST_CAPTURE, ST_RESP
    } state_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] owner_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  op_a_q;
    logic [W-1:0]  op_b_q;

    logic          win_vld_d;
    logic [PW-1:0] win_d;
    logic [PW-1:0] cand_d;
    logic [PW-1:0] ptr_d;
    logic [W-1:0]  win_a_d;
    logic [W-1:0]  win_b_d;

    // Rotating-priority search upward from ptr_q, plus operand mux for the winner.
    always_comb begin
        win_vld_d = 1'b0;
        win_d     = '0;
        cand_d    = '0;
        win_a_d   = '0;
        win_b_d   = '0;
        for (int k = 0; k < N; k++) begin
            cand_d = PW'((int'(ptr_q) + k) % N);
            if (!win_vld_d && req[cand_d]) begin
                win_vld_d = 1'b1;
                win_d     = cand_d;
            end else begin
                win_vld_d = win_vld_d;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (win_d == PW'(k)) begin
                win_a_d = req_a[k*W +: W];
                win_b_d = req_b[k*W +: W];
            end else begin
                win_a_d = win_a_d;
            end
        end
        ptr_d = (win_d == IDX_LAST) ? '0 : win_d + PW'(1);
    end

    // Sequencer FSM; every output is registered from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            add_en    <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            add_en    <= 1'b0;
            case (state_q)
                ST_ARB: begin
                    if (win_vld_d) begin
                        state_q <= ST_START;
                        owner_q <= win_d;
                        ptr_q   <= ptr_d;
                        op_a_q  <= win_a_d;
                        op_b_q  <= win_b_d;
                        add_a   <= win_a_d;
                        add_b   <= win_b_d;
                        gnt     <= N'(1) << win_d;
                        add_en  <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= ST_ARB;
                        busy    <= 1'b0;
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= '0;
                    busy    <= 1'b1;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    busy  <= 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_CAPTURE;
                        add_en  <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_CAPTURE: begin
                    // Adder sits in DONE here; the enable above sends it back to IDLE.
                    state_q   <= ST_RESP;
                    rsp_data  <= add_out;
                    rsp_valid <= N'(1) << owner_q;
                    busy      <= 1'b1;
                end
                ST_RESP: begin
                    state_q <= ST_ARB;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_ARB;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/add_serial_arb.md
# add_serial_arb

Round-robin arbiter and sequencer that shares one 8-bit bit-serial adder (`add_serial`) between `N` requesters. It accepts operand pairs from requesters and launches the adder with a one-cycle enable. It counts the adder's fixed serial latency, captures the result, and returns the adder to IDLE with a second enable pulse. It then delivers the sum to the owning requester. It sits between the client ports and the single `add_serial` instance.

## Interface
- `N`, default 4: number of requesters; 2..8.
- `W`, default 8: operand/result width; must match the adder.
- `ADD_CYCLES`, default 8: adder ADD-state cycles; equals `W`.

Ports:
- `clk` input, 1 bit: single clock; all logic on posedge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `req` input, `N` bits: per-requester request level.
- `req_a` input, `N*W` bits: operand A. Requester `i` uses bits `[i*W +: W]`.
- `req_b` input, `N*W` bits: operand B, same packing as `req_a`.
- `gnt` output, `N` bits: one-hot, one-cycle pulse; the operands were captured.
- `rsp_valid` output, `N` bits: one-hot, one-cycle pulse; `rsp_data` is valid for that requester.
- `rsp_data` output, `W` bits: sum, modulo 2^W; the carry-out is dropped.
- `busy` output, 1 bit: high in every state except ARB.
- `add_en` output, 1 bit: adder enable.
- `add_a` output, `W` bits: adder operand A.
- `add_b` output, `W` bits: adder operand B.
- `add_out` input, `W` bits: adder result.

## Operation
- The FSM has five states: ARB, START, WAIT, CAPTURE, RESP. The reset state is ARB.
- **ARB**
  - If `req` is 0, stay in ARB.
  - Otherwise the winner is the first set `req` bit, searching upward from `ptr` with wrap-around.
  - Latch `owner` = winner, `op_a` = `req_a[winner]`, `op_b` = `req_b[winner]`.
  - Set `ptr` = (winner+1) mod `N`, then go to START.
- **START**
  - `gnt[owner]` = 1, `add_en` = 1, `add_a` = `op_a`, `add_b` = `op_b`.
  - Clear `cnt` to 0 and go to WAIT.
- **WAIT**
  - `add_en` = 0 and `cnt` increments each cycle.
  - At `cnt` == `ADD_CYCLES`-1, go to CAPTURE.
- **CAPTURE**
  - The adder is in DONE. Register `rsp_data` <= `add_out`.
  - `add_en` = 1, which returns the adder from DONE to IDLE. Go to RESP.
- **RESP**
  - `rsp_valid[owner]` = 1 and `add_en` = 0. Go to ARB.
- **Registers:** `gnt`, `rsp_valid`, `add_en`, `add_a`, `add_b` and `busy` are all registered, decoded from the next state.
- **Held values:** `add_a`/`add_b` hold `op_a`/`op_b` outside START. `rsp_data` holds its value until the next CAPTURE.
- **`cnt` width:** `$clog2(ADD_CYCLES)` bits.
- **Requester contract:**
  - Hold `req` and the operands stable until `gnt` is seen.
  - Deasserting `req` before the grant withdraws the request with no side effects.
  - `req` from any requester is ignored while `busy`.
  - The owner may re-request immediately after `gnt`. It is arbitrated normally in the next ARB.
- **Fairness:** after requester `i` wins, it has lowest priority in the next ARB.
- **Reset:**
  - `rst` low at any time forces ARB, `ptr` = 0, `cnt` = 0 and `owner` = 0.
  - `op_a`, `op_b` and `rsp_data` clear to 0.
  - All outputs drop to 0 asynchronously.
  - An in-flight operation is discarded; no `rsp_valid` is issued.
  - The adder's reset must be driven from the same system reset (inverted to its active-high `rst`), so both blocks restart together.

## Timing
- **Reset values:** `gnt`, `rsp_valid`, `rsp_data`, `add_en`, `add_a`, `add_b` and `busy` are all 0.
- **Start edge:** the adder samples `add_en` at the edge ending START (edge E0). Its ADD state spans edges E1..E8, and DONE is reached after E8.
- **Per-operation cycles:** ARB 1, START 1, WAIT `ADD_CYCLES`, CAPTURE 1, RESP 1.
  - `gnt` appears 1 cycle after `req` is seen in ARB.
  - `rsp_valid` appears `ADD_CYCLES`+3 cycles after the ARB cycle: 11 cycles with the defaults.
- **Throughput:** one operation per `ADD_CYCLES`+4 cycles (12 with the defaults) under continuous requests.
- **Back-to-back:** the RESP→ARB→START sequence guarantees at least one `add_en`=0 cycle while the adder is IDLE before the next start.

## Test plan
- **Single request, no overflow:** reset, then `req[0]` with a=8'h35, b=8'h1C.
  - Expect `gnt[0]` in cycle 2.
  - Expect `rsp_valid[0]` 11 cycles after the ARB cycle with `rsp_data` = 8'h51.
  - Expect `add_en` high exactly in START and CAPTURE.
- **Overflow:** a=8'hFF, b=8'h02 → `rsp_data` = 8'h01. Also a=8'h80, b=8'h80 → 8'h00.
- **Round-robin:** hold all four `req` high, each with distinct operands.
  - Grants must come in order 0,1,2,3,0.
  - Grants must be exactly 12 cycles apart.
  - Each `rsp_valid[i]` must carry requester `i`'s sum.
- **Pointer wrap and skip:** win with `req[3]`, then raise `req[1]` and `req[0]` together.
  - Expect the grant to go to 0, then to 1.
- **Withdrawal and busy:**
  - Drop `req[2]` before it is granted → no `gnt[2]`, FSM stays in ARB.
  - Raise `req[1]` in mid-WAIT → it is granted only after RESP.
- **Mid-operation reset:** assert `rst` low during WAIT with `cnt` = 4, then release.
  - All outputs must be 0 with no `rsp_valid`.
  - A new request must complete with the correct sum, proving the adder restarted cleanly.
